// File: rtl/spi_pkg.sv
// Shared SPI frame layout, FSM state type and frame packer for the master and slave sides.
package spi_pkg;

    localparam int FRAME_W  = 32;
    localparam int DATA_W   = 12;
    localparam int ADDR_W   = 6;
    localparam int RWB_POS  = 0;
    localparam int ADDR_LSB = 8;
    localparam int DATA_LSB = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } spi_state_e;

    function automatic logic [FRAME_W-1:0] spi_pack(
        input logic              rwb,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        logic [FRAME_W-1:0] f;
        f                       = '0;
        f[RWB_POS]              = rwb;
        f[ADDR_LSB +: ADDR_W]   = addr;
        f[DATA_LSB +: DATA_W]   = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator and spi_clk level; rise/fall strobe on the tick that toggles the level.
// Zero latency strobes; counter restarts whenever cnt_en drops.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic sclk,
    input  logic rstn,
    input  logic cnt_en,
    input  logic tgl_en,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic clk_lvl
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;

    always_comb begin
        tick  = cnt_en && (cnt_q == CW'(CLK_DIV - 1));
        rise  = tick && tgl_en && !lvl_q;
        fall  = tick && tgl_en && lvl_q;
        cnt_d = (!cnt_en || tick) ? '0 : cnt_q + 1'b1;
        lvl_d = (rise || fall) ? !lvl_q : lvl_q;
    end

    always_ff @(posedge sclk) begin
        if (!rstn) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign clk_lvl = lvl_q;

endmodule

// File: rtl/spi_ms.sv
// SPI mode-0 master: writes take one frame, reads two (second frame's rx returned).
// Latency 65*CLK_DIV+HOLD_CYC+GAP_CYC per frame; req_ready only in IDLE, nothing queued while busy.
module spi_ms
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int HOLD_CYC = 8,
    parameter int GAP_CYC  = 16
) (
    input  logic        sclk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rwb,
    input  logic [5:0]  req_addr,
    input  logic [11:0] req_data,
    output logic        rsp_valid,
    output logic [11:0] rsp_data,
    output logic        busy,
    output logic        spi_clk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int HG_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int HG_W   = $clog2(HG_MAX + 1);

    spi_state_e         state_q, state_d;
    logic               rwb_q, rwb_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               pass_q, pass_d;
    logic [5:0]         edge_q, edge_d;
    logic [HG_W-1:0]    hg_q, hg_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               ready_q, ready_d;
    logic               cs_n_q, cs_n_d;
    logic               mosi_q, mosi_d;
    logic [FRAME_W-1:0] frame;
    logic               hs, tick, rise, fall;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .sclk    (sclk),
        .rstn    (rstn),
        .cnt_en  (state_q == LEAD || state_q == SHIFT),
        .tgl_en  (state_q == SHIFT),
        .tick    (tick),
        .rise    (rise),
        .fall    (fall),
        .clk_lvl (spi_clk)
    );

    always_comb begin
        state_d     = state_q;
        rwb_d       = rwb_q;
        addr_d      = addr_q;
        data_d      = data_q;
        pass_d      = pass_q;
        edge_d      = edge_q;
        hg_d        = hg_q;
        rx_d        = rx_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        hs          = req_valid && ready_q;

        case (state_q)
            IDLE: if (hs) begin
                state_d = LEAD;
                rwb_d   = req_rwb;
                addr_d  = req_addr;
                data_d  = req_data;
                pass_d  = 1'b0;
            end
            LEAD: if (tick) state_d = SHIFT;
            SHIFT: begin
                // edge_q counts half-periods; odd values end on a falling edge
                if (rise || fall) edge_d = edge_q + 6'd1;
                if (fall && edge_q[5:1] < 5'(DATA_W)) rx_d[edge_q[4:1]] = spi_miso;
                if (fall && edge_q == 6'd63) begin
                    state_d = TRAIL;
                    hg_d    = '0;
                end
            end
            TRAIL: begin
                if (hg_q == HG_W'(HOLD_CYC - 1)) begin
                    state_d = GAP;
                    hg_d    = '0;
                end else begin
                    hg_d = hg_q + 1'b1;
                end
            end
            GAP: begin
                if (hg_q == HG_W'(GAP_CYC - 1)) begin
                    hg_d = '0;
                    if (rwb_q && !pass_q) begin
                        state_d = LEAD;
                        pass_d  = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rwb_q ? rx_q : '0;
                    end
                end else begin
                    hg_d = hg_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        frame = spi_pack(rwb_d, addr_d, data_d);
        if (state_d == LEAD) begin
            mosi_d = frame[0];
        end else if (state_d == IDLE || state_d == GAP) begin
            mosi_d = 1'b0;
        end else if (fall && edge_q != 6'd63) begin
            mosi_d = frame[edge_q[5:1] + 5'd1];
        end

        ready_d = (state_d == IDLE);
        cs_n_d  = !(state_d inside {LEAD, SHIFT, TRAIL});
    end

    always_ff @(posedge sclk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rwb_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            pass_q      <= 1'b0;
            edge_q      <= '0;
            hg_q        <= '0;
            rx_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ready_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rwb_q       <= rwb_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            pass_q      <= pass_d;
            edge_q      <= edge_d;
            hg_q        <= hg_d;
            rx_q        <= rx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ready_q     <= ready_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_ms.sv
// Bench for spi_ms: behavioural register-file slave on the SPI pins, vector table, random traffic, reset abort, CLK_DIV=255.
module tb_spi_ms;
    import spi_pkg::*;

    localparam int FRAME_CYC = 65 * 2 + 8 + 16;

    logic sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic        rstn, req_valid, req_ready, req_rwb, rsp_valid, busy;
    logic [5:0]  req_addr;
    logic [11:0] req_data, rsp_data;
    logic        spi_clk, spi_cs_n, spi_mosi, spi_miso;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_busy, b_spi_clk, b_cs_n, b_mosi;
    logic [11:0] b_rsp_data;

    spi_ms #(.CLK_DIV(2), .HOLD_CYC(8), .GAP_CYC(16)) u_dut (
        .sclk(sclk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_rwb(req_rwb), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_ms #(.CLK_DIV(255), .HOLD_CYC(8), .GAP_CYC(16)) u_big (
        .sclk(sclk), .rstn(rstn), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_rwb(1'b0), .req_addr(6'h05), .req_data(12'hABC),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .busy(b_busy),
        .spi_clk(b_spi_clk), .spi_cs_n(b_cs_n), .spi_mosi(b_mosi), .spi_miso(1'b0)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model: 64 x 12-bit registers, read data returned one frame later
    int               miso_mode = 0;          // 0 = slave drives, 1 = tied high, 2 = tied low
    logic [11:0]      s_mem [64] = '{default: 12'h000};
    logic [5:0]       s_last_addr = 6'h00;
    logic [31:0]      s_out = 32'h0;
    logic [31:0]      s_in  = 32'h0;
    int               s_rise_total = 0, s_rise_base = 0, s_fall_total = 0, s_fall_base = 0;
    int               s_bits, s_falls, s_rise_cnt_total;
    logic [31:0]      frames_q [$];
    int               rises_q  [$];

    assign s_bits  = s_rise_total - s_rise_base;
    assign s_falls = s_fall_total - s_fall_base;
    assign s_rise_cnt_total = s_rise_total;
    assign spi_miso = (miso_mode == 1) ? 1'b1 :
                      (miso_mode == 2) ? 1'b0 :
                      (s_falls < 32)   ? s_out[s_falls[4:0]] : 1'b0;

    always @(negedge spi_cs_n) begin
        s_rise_base = s_rise_total;
        s_fall_base = s_fall_total;
        s_out       = $urandom();
        s_out[11:0] = s_mem[s_last_addr];
    end

    always @(posedge spi_clk) if (!spi_cs_n) begin
        if (s_bits < 32) s_in[s_bits[4:0]] = spi_mosi;
        s_rise_total = s_rise_total + 1;
    end

    always @(negedge spi_clk) if (!spi_cs_n) s_fall_total = s_fall_total + 1;

    always @(posedge spi_cs_n) begin
        if (s_bits == 32) begin
            frames_q.push_back(s_in);
            if (s_in[0]) s_last_addr = s_in[13:8];
            else         s_mem[s_in[13:8]] = s_in[27:16];
        end
        rises_q.push_back(s_bits);
    end

    // ---------------- capture for the CLK_DIV = 255 instance
    int          b_rise_total = 0, b_rise_base = 0;
    logic [31:0] b_word = 32'h0;
    time         b_t [2];
    always @(negedge b_cs_n) b_rise_base = b_rise_total;
    always @(posedge b_spi_clk) if (!b_cs_n) begin
        if (b_rise_total - b_rise_base < 32) b_word[5'(b_rise_total - b_rise_base)] = b_mosi;
        if (b_rise_total - b_rise_base < 2) b_t[b_rise_total - b_rise_base] = $time;
        b_rise_total = b_rise_total + 1;
    end

    // One complete transaction with latency, response, frame and edge checks.
    task automatic do_txn(input string name, input logic rwb, input logic [5:0] addr,
                          input logic [11:0] data, input logic [11:0] exp_rsp);
        int hs_cyc, n_fr, f0, r0;
        bit got;
        logic [31:0] exp_fr;
        exp_fr = {4'b0, data, 2'b0, addr, 7'b0, rwb};
        n_fr   = rwb ? 2 : 1;
        f0     = frames_q.size();
        r0     = rises_q.size();
        @(negedge sclk);
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge sclk);
        check($sformatf("%s_ready", name), req_ready, 1);
        req_valid = 1'b1; req_rwb = rwb; req_addr = addr; req_data = data;
        @(posedge sclk); #1;
        req_valid = 1'b0;
        hs_cyc = cyc;
        got = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sclk);
            if (rsp_valid) begin got = 1; break; end
        end
        check($sformatf("%s_latency", name), got ? cyc - hs_cyc : -1, n_fr * FRAME_CYC);
        check($sformatf("%s_rsp_data", name), rsp_data, exp_rsp);
        @(negedge sclk);
        check($sformatf("%s_rsp_pulse", name), rsp_valid, 0);
        check($sformatf("%s_rsp_hold", name), rsp_data, exp_rsp);
        check($sformatf("%s_frames", name), frames_q.size() - f0, n_fr);
        check($sformatf("%s_cs_pulses", name), rises_q.size() - r0, n_fr);
        for (int k = 0; k < n_fr; k++) begin
            if (f0 + k < frames_q.size())
                check($sformatf("%s_frame%0d", name, k), frames_q[f0 + k], exp_fr);
            if (r0 + k < rises_q.size())
                check($sformatf("%s_rises%0d", name, k), rises_q[r0 + k], 32);
        end
    endtask

    typedef struct {
        logic        rwb;
        logic [5:0]  addr;
        logic [11:0] data;
        int          mode;
        logic [11:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [11:0] ref_mem [64];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs, viol, r0, pulses;
        bit got;
        logic        rr;
        logic [5:0]  ra;
        logic [11:0] rd;

        vecs[0] = '{1'b0, 6'h05, 12'hABC, 0, 12'h000};
        vecs[1] = '{1'b1, 6'h05, 12'h000, 0, 12'hABC};
        vecs[2] = '{1'b1, 6'h2A, 12'h000, 1, 12'hFFF};
        vecs[3] = '{1'b1, 6'h11, 12'h000, 2, 12'h000};
        vecs[4] = '{1'b0, 6'h3F, 12'h123, 0, 12'h000};
        vecs[5] = '{1'b1, 6'h3F, 12'h000, 0, 12'h123};
        vecs[6] = '{1'b0, 6'h00, 12'hFFF, 0, 12'h000};
        vecs[7] = '{1'b1, 6'h00, 12'h000, 0, 12'hFFF};
        for (int i = 0; i < 64; i++) ref_mem[i] = 12'h000;

        rstn = 1'b0; req_valid = 1'b0; req_rwb = 1'b0; req_addr = '0; req_data = '0;
        b_req_valid = 1'b0;
        repeat (4) @(negedge sclk);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_spi_clk", spi_clk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        rstn = 1'b1;
        @(negedge sclk);
        check("rst_ready_returns", req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            miso_mode = vecs[i].mode;
            do_txn($sformatf("vec%0d", i), vecs[i].rwb, vecs[i].addr, vecs[i].data, vecs[i].exp);
            if (!vecs[i].rwb) ref_mem[vecs[i].addr] = vecs[i].data;
        end
        miso_mode = 0;

        // req_valid held high across a whole write
        @(negedge sclk);
        req_valid = 1'b1; req_rwb = 1'b0; req_addr = 6'h07; req_data = 12'h5A5;
        @(posedge sclk); #1;
        viol = 0; got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sclk);
            if (rsp_valid) begin got = 1; break; end
            if (req_ready) viol++;
        end
        check("hold_ready_low_while_busy", viol, 0);
        check("hold_first_rsp_seen", got, 1);
        check("hold_ready_with_rsp", req_ready, 1);
        @(negedge sclk);
        check("hold_second_accepted", busy, 1);
        req_valid = 1'b0;
        hs = cyc; got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sclk);
            if (rsp_valid) begin got = 1; break; end
        end
        check("hold_second_latency", got ? cyc - hs : -1, FRAME_CYC);
        ref_mem[7] = 12'h5A5;

        // reset at the 10th falling spi_clk edge of a write
        @(negedge sclk);
        req_valid = 1'b1; req_rwb = 1'b0; req_addr = 6'h09; req_data = 12'h321;
        @(posedge sclk); #1;
        req_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sclk);
            if (s_falls >= 10) begin got = 1; break; end
        end
        check("abort_reached_fall10", got, 1);
        rstn = 1'b0;
        @(negedge sclk);
        check("abort_cs_n", spi_cs_n, 1);
        check("abort_spi_clk", spi_clk, 0);
        check("abort_busy", busy, 0);
        check("abort_ready_in_reset", req_ready, 0);
        r0 = s_rise_cnt_total;
        rstn = 1'b1;
        @(negedge sclk);
        check("abort_ready_after_release", req_ready, 1);
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sclk);
            if (rsp_valid) pulses++;
        end
        check("abort_no_rsp", pulses, 0);
        check("abort_no_extra_edge", s_rise_cnt_total - r0, 0);
        do_txn("post_abort_wr", 1'b0, 6'h09, 12'h321, 12'h000);
        ref_mem[9] = 12'h321;

        // random traffic against the register-file reference
        for (int i = 0; i < 12; i++) begin
            rr = 1'($urandom_range(0, 1));
            ra = 6'($urandom_range(0, 9));
            rd = 12'($urandom());
            do_txn($sformatf("rnd%0d", i), rr, ra, rd, rr ? ref_mem[ra] : 12'h000);
            if (!rr) ref_mem[ra] = rd;
        end

        // CLK_DIV = 255 write
        @(negedge sclk);
        b_req_valid = 1'b1;
        @(posedge sclk); #1;
        b_req_valid = 1'b0;
        hs = cyc; got = 0;
        r0 = b_rise_total;
        for (int i = 0; i < 20000; i++) begin
            @(negedge sclk);
            if (b_rsp_valid) begin got = 1; break; end
        end
        check("big_latency", got ? cyc - hs : -1, 65 * 255 + 8 + 16);
        check("big_rsp_data", b_rsp_data, 0);
        check("big_rises", b_rise_total - r0, 32);
        check("big_frame", b_word, 32'h0ABC0500);
        check("big_period", 32'((b_t[1] - b_t[0]) / 10), 510);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_ms.md
SPI_MS -- requirements
Module: spi_ms

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sclk cycles per spi_clk half-period (legal range 2..255).
REQ-002 SHALL have parameter HOLD_CYC, default 8: sclk cycles cs_n stays low after the last falling spi_clk edge.
REQ-003 SHALL have parameter GAP_CYC, default 16: sclk cycles cs_n stays high between frames and after each transaction.
REQ-004 SHALL have ports, clock and reset first:
- sclk  in  1  system clock; all logic on rising edge.
- rstn  in  1  reset; synchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when high with req_valid.
- req_rwb  in  1  1 = read, 0 = write.
- req_addr  in  6  register address.
- req_data  in  12  write data, ignored on reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  12  read data; 0 on writes.
- busy  out  1  high in any state other than IDLE.
- spi_clk  out  1  serial clock, mode 0, idles low.
- spi_cs_n  out  1  chip select, active low.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.

Function
REQ-005 SHALL build each 32-bit frame as {4'b0, DATA[11:0], 2'b0, ADDR[5:0], 7'b0, RWb} and shift it LSB first.
REQ-006 SHALL assert req_ready only in IDLE, latching rwb, addr and data on the handshake cycle.
REQ-007 SHALL use FSM states IDLE, LEAD, SHIFT, TRAIL, GAP; IDLE -> LEAD on handshake.
REQ-008 In LEAD, SHALL hold cs_n = 0, spi_clk = 0 and mosi = frame bit 0 for CLK_DIV cycles, then enter SHIFT.
REQ-009 In SHIFT, SHALL toggle spi_clk every CLK_DIV cycles for 32 full periods (64*CLK_DIV cycles).
REQ-010 SHALL sample spi_miso on each falling spi_clk edge k (k = 1..32) into rx bit k-1.
REQ-011 SHALL update mosi to frame bit k on falling edge k (k = 1..31); mosi is otherwise stable while spi_clk is high.
REQ-012 After the 32nd falling edge, SHALL enter TRAIL, keeping cs_n = 0 and spi_clk = 0 for HOLD_CYC cycles, then enter GAP with cs_n = 1.
REQ-013 SHALL complete a write in one frame: after GAP_CYC cycles, return to IDLE and pulse rsp_valid with rsp_data = 0 in the same cycle.
REQ-014 SHALL run a read as two identical read frames separated by GAP. Only frame 2's rx[11:0] is returned on rsp_data with the rsp_valid pulse after the second GAP.
REQ-015 A write therefore completes 65*CLK_DIV + HOLD_CYC + GAP_CYC cycles after the handshake; a read takes exactly twice that.
REQ-016 rsp_data SHALL hold its value until the next rsp_valid pulse.
REQ-017 SHALL ignore req_valid while busy, with no queuing.
REQ-018 SHALL ignore bits 31:12 of rx.
REQ-019 Counters SHALL size as: half-period counter $clog2(CLK_DIV), edge counter 6 bits, hold/gap counter sized for max(HOLD_CYC, GAP_CYC), with no wrap inside a phase.

Reset
REQ-020 While rstn = 0 at a sclk edge, SHALL force IDLE, cs_n = 1, spi_clk = 0, mosi = 0, rsp_valid = 0, rsp_data = 0, busy = 0 and req_ready = 0.
REQ-021 Reset mid-frame SHALL abort within one cycle, with no rsp_valid and no extra spi_clk edge; req_ready returns the cycle after rstn rises.

Structure
REQ-022 Package spi_pkg SHALL hold FRAME_W = 32, DATA_W = 12, ADDR_W = 6, field bit positions, the state enum type, and a frame-pack function; the slave also uses spi_pkg.
REQ-023 Sub-module spi_clk_div SHALL generate half-period ticks and rise/fall strobes; the FSM and shifters stay in spi_ms.

Verification (CLK_DIV = 2, HOLD_CYC = 8, GAP_CYC = 16, slave model on spi_clk)
REQ-024 Write addr 0x05, data 0xABC -> mosi carries 0x0ABC0500 LSB first over 32 rising edges; rsp_valid 154 cycles after the handshake with rsp_data = 0.
REQ-025 Write 0xABC to 0x05, then read 0x05 -> two cs_n low pulses; rsp_valid 308 cycles after the read handshake with rsp_data = 0xABC.
REQ-026 spi_miso tied to 1, read any address -> rsp_data = 0xFFF; tied to 0 -> rsp_data = 0x000.
REQ-027 req_valid held high across a write -> req_ready low until rsp_valid; second request accepted on the cycle after rsp_valid.
REQ-028 rstn low at falling edge 10 of a write -> cs_n = 1 and spi_clk = 0 next cycle, no rsp_valid; a following write completes normally.
REQ-029 CLK_DIV = 255 write -> spi_clk period 510 cycles, 32 rising edges, frame content unchanged.
